// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps in1..3 through all 8 rows, samples gate_out twice per row, reports table_out/unstable/match with busy/done handshake
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 4,
  parameter logic [7:0] EXPECTED = 8'hF4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gate_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic [7:0] unstable,
  output logic       match
);
  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE_A, SAMPLE_B, DONE} state_t;
  localparam logic [7:0] LOAD = 8'(SETTLE_CYCLES - 1);
  state_t state;
  logic [2:0] row;
  logic [7:0] cnt;
  logic sa;
  logic [7:0] t_nx, u_nx;
  always_comb begin
    t_nx = table_out;
    u_nx = unstable;
    t_nx[~row] = gate_out;
    u_nx[~row] = sa ^ gate_out;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row <= '0;
      cnt <= '0;
      sa <= 1'b0;
      {in1, in2, in3} <= 3'b000;
      busy <= 1'b0;
      done <= 1'b0;
      table_out <= '0;
      unstable <= '0;
      match <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          row <= '0;
          {in1, in2, in3} <= 3'b000;
          cnt <= LOAD;
          table_out <= '0;
          unstable <= '0;
          match <= 1'b0;
          busy <= 1'b1;
          state <= SETTLE;
        end
        SETTLE: begin
          cnt <= cnt - 8'd1;
          state <= cnt == 8'd0 ? SAMPLE_A : SETTLE;
        end
        SAMPLE_A: begin
          sa <= gate_out;
          state <= SAMPLE_B;
        end
        SAMPLE_B: begin
          table_out <= t_nx;
          unstable <= u_nx;
          if (row == 3'd7) begin
            {in1, in2, in3} <= 3'b000;
            busy <= 1'b0;
            done <= 1'b1;
            match <= (t_nx == EXPECTED) && (u_nx == 8'h00);
            state <= DONE;
          end else begin
            row <= row + 3'd1;
            {in1, in2, in3} <= row + 3'd1;
            cnt <= LOAD;
            state <= SETTLE;
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: randomized gate models against a cycle-level reference of the sweep schedule
module tb_truth_table_sweeper;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic st [2] = '{1'b0, 1'b0};
  logic rs [2] = '{1'b0, 1'b0};
  logic go [2] = '{1'b0, 1'b0};
  logic i1 [2];
  logic i2 [2];
  logic i3 [2];
  logic bz [2];
  logic dn [2];
  logic mt [2];
  logic [7:0] tt [2];
  logic [7:0] un [2];
  int passed = 0, failed = 0, total = 0;
  truth_table_sweeper #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rs[0]), .start(st[0]), .gate_out(go[0]),
    .in1(i1[0]), .in2(i2[0]), .in3(i3[0]), .busy(bz[0]), .done(dn[0]),
    .table_out(tt[0]), .unstable(un[0]), .match(mt[0])
  );
  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rs[1]), .start(st[1]), .gate_out(go[1]),
    .in1(i1[1]), .in2(i2[1]), .in3(i3[1]), .busy(bz[1]), .done(dn[1]),
    .table_out(tt[1]), .unstable(un[1]), .match(mt[1])
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input int d, input string tag);
    chk({tag, "_ins"}, {29'd0, i1[d], i2[d], i3[d]}, 0);
    chk({tag, "_busy"}, {31'd0, bz[d]}, 0);
    chk({tag, "_done"}, {31'd0, dn[d]}, 0);
    chk({tag, "_table"}, {24'd0, tt[d]}, 0);
    chk({tag, "_unstable"}, {24'd0, un[d]}, 0);
    chk({tag, "_match"}, {31'd0, mt[d]}, 0);
  endtask
  task automatic idle(input int d, input int k);
    repeat (k) begin
      chk("idle_busy", {31'd0, bz[d]}, 0);
      chk("idle_done", {31'd0, dn[d]}, 0);
      step();
    end
  endtask
  task automatic sweep(input int d, input logic [7:0] code, input int frow, input bit hold, input int abort_at);
    int s, n, r, p;
    logic [7:0] eu;
    s = d ? 1 : 4;
    n = 8 * (s + 2);
    eu = frow >= 0 ? 8'h80 >> frow : 8'h00;
    st[d] = 1'b1;
    step();
    for (int c = 1; c <= n; c++) begin
      r = (c - 1) / (s + 2);
      p = (c - 1) % (s + 2);
      chk("row_inputs", {29'd0, i1[d], i2[d], i3[d]}, r);
      chk("busy_high", {31'd0, bz[d]}, 1);
      chk("done_early", {31'd0, dn[d]}, 0);
      if (c == 1) begin
        chk("start_clr_table", {24'd0, tt[d]}, 0);
        chk("start_clr_unstable", {24'd0, un[d]}, 0);
        chk("start_clr_match", {31'd0, mt[d]}, 0);
      end
      st[d] = hold ? 1'b1 : 1'($urandom);
      go[d] = p < s ? 1'($urandom) : code[7 - r] ^ (p == s && r == frow);
      if (c == abort_at) begin
        rs[d] = 1'b1;
        step();
        rs[d] = 1'b0;
        st[d] = 1'b0;
        chk_zero(d, "abort");
        idle(d, 2 * n);
        return;
      end
      step();
    end
    chk("done_pulse", {31'd0, dn[d]}, 1);
    chk("done_busy", {31'd0, bz[d]}, 0);
    chk("done_ins", {29'd0, i1[d], i2[d], i3[d]}, 0);
    chk("table", {24'd0, tt[d]}, {24'd0, code});
    chk("unstable", {24'd0, un[d]}, {24'd0, eu});
    chk("match", {31'd0, mt[d]}, {31'd0, (code == 8'hF4) && (eu == 8'h00)});
    step();
    chk("done_once", {31'd0, dn[d]}, 0);
    chk("idle_after_done", {31'd0, bz[d]}, 0);
    chk("table_held", {24'd0, tt[d]}, {24'd0, code});
    chk("unstable_held", {24'd0, un[d]}, {24'd0, eu});
    st[d] = hold;
  endtask
  initial begin
    rs[0] = 1'b1;
    rs[1] = 1'b1;
    st[0] = 1'b1;
    step();
    step();
    chk_zero(0, "reset4");
    chk_zero(1, "reset1");
    rs[0] = 1'b0;
    rs[1] = 1'b0;
    st[0] = 1'b0;
    idle(0, 3);
    sweep(0, 8'hF4, -1, 1'b0, 0);
    idle(0, 2);
    sweep(0, 8'hFF, -1, 1'b0, 0);
    idle(0, 1);
    sweep(0, 8'hFF, -1, 1'b0, 0);
    idle(0, 2);
    sweep(0, 8'hF4, 5, 1'b0, 0);
    idle(0, 2);
    sweep(0, 8'hF4, -1, 1'b1, 0);
    sweep(0, 8'hF4, -1, 1'b1, 0);
    st[0] = 1'b0;
    idle(0, 3);
    sweep(0, 8'hF4, -1, 1'b0, 20);
    sweep(0, 8'hF4, -1, 1'b0, 0);
    idle(0, 1);
    for (int k = 0; k < 5; k++) begin
      sweep(0, 8'($urandom), int'($urandom_range(0, 8)) - 1, 1'b0, 0);
      idle(0, int'($urandom_range(0, 3)));
    end
    sweep(1, 8'hF4, -1, 1'b0, 0);
    idle(1, 1);
    for (int k = 0; k < 5; k++) begin
      sweep(1, 8'($urandom), int'($urandom_range(0, 8)) - 1, 1'b0, 0);
      idle(1, int'($urandom_range(0, 3)));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
